event_readout_sequencer: RTL and testbench

//  Sequences per-event readout through the TURFIO completion tracker in the aclk domain.
//  - Accepts one event-buffer request at a time.
//  - Snapshots the TURFIO mask and arms the tracker's enable.
//  - Waits for tracker completion or a timeout, then emits a done record (buffer index, status).
//  - Counts outstanding buffers and refuses new events once NBUF are held downstream.

---
 rtl/event_readout_sequencer.sv | 136 +++++++++++++
 tb/tb_event_readout_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_readout_sequencer.sv
// Event readout sequencer: accepts one event-buffer request, arms the TURFIO completion
// tracker with a mask snapshot, waits for completion or timeout, then emits a done record.
module event_readout_sequencer #(
    parameter int NBUF_BITS = 2,
    parameter int TIMEOUT   = 65535,
    parameter int HOLDOFF   = 4
) (
    input  logic                   aclk,
    input  logic                   aclk_rst,
    input  logic                   s_evt_tvalid,
    output logic                   s_evt_tready,
    input  logic [NBUF_BITS-1:0]   s_evt_tdata,
    input  logic [3:0]             tio_mask_i,
    output logic [3:0]             tio_mask_o,
    output logic                   enable_o,
    input  logic                   complete_i,
    input  logic [3:0]             err_i,
    output logic                   m_done_tvalid,
    input  logic                   m_done_tready,
    output logic [NBUF_BITS+4:0]   m_done_tdata,
    input  logic                   release_i,
    output logic [NBUF_BITS:0]     outstanding_o,
    output logic                   release_err_o
);
    localparam int NBUF = 1 << NBUF_BITS;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int HW   = $clog2(HOLDOFF + 1);
    localparam int OW   = NBUF_BITS + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPORT, ST_HOLD} state_t;

    state_t               state_q, state_d;
    logic [NBUF_BITS-1:0] index_q, index_d;
    logic [3:0]           mask_q, mask_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [HW-1:0]        holdoff_q, holdoff_d;
    logic                 timeout_q, timeout_d;
    logic [3:0]           err_q, err_d;
    logic [OW-1:0]        outstanding_q, outstanding_d;
    logic                 rel_err_q, rel_err_d;
    logic                 accept;
    logic                 release_ok;

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            state_q       <= ST_IDLE;
            index_q       <= '0;
            mask_q        <= '0;
            timer_q       <= '0;
            holdoff_q     <= '0;
            timeout_q     <= 1'b0;
            err_q         <= '0;
            outstanding_q <= '0;
            rel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            mask_q        <= mask_d;
            timer_q       <= timer_d;
            holdoff_q     <= holdoff_d;
            timeout_q     <= timeout_d;
            err_q         <= err_d;
            outstanding_q <= outstanding_d;
            rel_err_q     <= rel_err_d;
        end
    end

    assign s_evt_tready  = (state_q == ST_IDLE) && (outstanding_q < OW'(NBUF));
    assign accept        = s_evt_tvalid && s_evt_tready;
    assign enable_o      = (state_q == ST_WAIT);
    assign m_done_tvalid = (state_q == ST_REPORT);
    assign m_done_tdata  = {timeout_q, err_q, index_q};
    assign tio_mask_o    = mask_q;
    assign outstanding_o = outstanding_q;
    assign release_err_o = rel_err_q;
    assign release_ok    = release_i && (outstanding_q != '0);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        mask_d    = mask_q;
        timer_d   = timer_q;
        holdoff_d = holdoff_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    index_d = s_evt_tdata;
                    mask_d  = tio_mask_i;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion takes priority over a coincident timer expiry.
                if (complete_i) begin
                    timeout_d = 1'b0;
                    err_d     = err_i;
                    state_d   = ST_REPORT;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    err_d     = err_i;
                    state_d   = ST_REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REPORT: begin
                if (m_done_tready) begin
                    holdoff_d = '0;
                    state_d   = ST_HOLD;
                end
            end
            default: begin
                // Keep enable low long enough for the tracker's enable pipeline to drain.
                if (holdoff_q == HW'(HOLDOFF - 1)) begin
                    holdoff_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    holdoff_d = holdoff_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        rel_err_d     = rel_err_q | (release_i && (outstanding_q == '0));
        case ({accept, release_ok})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end
endmodule

// File: tb/tb_event_readout_sequencer.sv
// Scenario bench for event_readout_sequencer: expected done records are queued when an
// event is driven and compared when the sequencer hands them over.
module tb_event_readout_sequencer;
    localparam int TO = 16;
    localparam int HO = 4;

    logic       aclk = 1'b0;
    logic       aclk_rst;
    logic       s_evt_tvalid;
    logic       s_evt_tready;
    logic [1:0] s_evt_tdata;
    logic [3:0] tio_mask_i;
    logic [3:0] tio_mask_o;
    logic       enable_o;
    logic       complete_i;
    logic [3:0] err_i;
    logic       m_done_tvalid;
    logic       m_done_tready;
    logic [6:0] m_done_tdata;
    logic       release_i;
    logic [2:0] outstanding_o;
    logic       release_err_o;

    int         total = 0;
    int         passed = 0;
    logic [6:0] exp_q[$];
    logic [2:0] exp_out = '0;
    logic       exp_err = 1'b0;

    event_readout_sequencer #(.NBUF_BITS(2), .TIMEOUT(TO), .HOLDOFF(HO)) dut (
        .aclk(aclk), .aclk_rst(aclk_rst),
        .s_evt_tvalid(s_evt_tvalid), .s_evt_tready(s_evt_tready), .s_evt_tdata(s_evt_tdata),
        .tio_mask_i(tio_mask_i), .tio_mask_o(tio_mask_o), .enable_o(enable_o),
        .complete_i(complete_i), .err_i(err_i),
        .m_done_tvalid(m_done_tvalid), .m_done_tready(m_done_tready), .m_done_tdata(m_done_tdata),
        .release_i(release_i), .outstanding_o(outstanding_o), .release_err_o(release_err_o)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_release();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        if (exp_out != 0) exp_out = exp_out - 1'b1;
        else exp_err = 1'b1;
        total++;
        if (outstanding_o !== exp_out) $display("FAIL release_count act=%0d req=%0d", outstanding_o, exp_out);
        else passed++;
        total++;
        if (release_err_o !== exp_err) $display("FAIL release_err act=%0b req=%0b", release_err_o, exp_err);
        else passed++;
    endtask

    // Hands over the pending done record after 'stall' cycles of back-pressure, then checks holdoff.
    task automatic collect_done(input int stall);
        logic [6:0] held;
        logic [6:0] exp;
        total++;
        if (m_done_tvalid !== 1'b1) $display("FAIL done_valid act=%0b req=1", m_done_tvalid);
        else passed++;
        held = m_done_tdata;
        if (stall > 0) begin
            s_evt_tvalid = 1'b1;
            s_evt_tdata  = 2'd3;
        end
        for (int i = 0; i < stall; i++) begin
            step();
            total++;
            if (m_done_tvalid !== 1'b1 || m_done_tdata !== held || s_evt_tready !== 1'b0 ||
                outstanding_o !== exp_out)
                $display("FAIL report_stall cyc=%0d act=v%0b d%h r%0b o%0d req=v1 d%h r0 o%0d",
                         i, m_done_tvalid, m_done_tdata, s_evt_tready, outstanding_o, held, exp_out);
            else passed++;
        end
        s_evt_tvalid  = 1'b0;
        m_done_tready = 1'b1;
        exp = exp_q.pop_front();
        $display("done record tdata=%h (timeout=%0b err=%h idx=%0d)", m_done_tdata,
                 m_done_tdata[6], m_done_tdata[5:2], m_done_tdata[1:0]);
        total++;
        if (m_done_tdata !== exp) $display("FAIL done_tdata act=%h req=%h", m_done_tdata, exp);
        else passed++;
        step();
        m_done_tready = 1'b0;
        for (int i = 0; i < HO; i++) begin
            total++;
            if (enable_o !== 1'b0 || s_evt_tready !== 1'b0 || m_done_tvalid !== 1'b0)
                $display("FAIL holdoff cyc=%0d act=en%0b rdy%0b v%0b req=en0 rdy0 v0",
                         i, enable_o, s_evt_tready, m_done_tvalid);
            else passed++;
            step();
        end
        total++;
        if (s_evt_tready !== (exp_out < 3'd4))
            $display("FAIL back_to_idle act=%0b req=%0b", s_evt_tready, exp_out < 3'd4);
        else passed++;
    endtask

    // ncomp==0 means the tracker never completes.
    task automatic do_event(input logic [1:0] idx, input logic [3:0] mask, input int ncomp,
                            input logic [3:0] err, input int stall, input logic rel_at_accept);
        logic exp_to;
        int   nwait;
        int   en_cnt;
        int   waited;
        exp_to = (ncomp == 0 || ncomp > TO);
        nwait  = exp_to ? TO : ncomp;
        exp_q.push_back({exp_to, err, idx});
        s_evt_tvalid = 1'b1;
        s_evt_tdata  = idx;
        tio_mask_i   = mask;
        waited = 0;
        while (s_evt_tready !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (waited >= 200) begin
            total++;
            $display("FAIL accept_timeout act=not_ready req=ready");
        end
        release_i = rel_at_accept;
        step();
        s_evt_tvalid = 1'b0;
        release_i    = 1'b0;
        tio_mask_i   = ~mask;
        if (!(rel_at_accept && exp_out != 0)) exp_out = exp_out + 1'b1;
        total++;
        if (outstanding_o !== exp_out) $display("FAIL accept_count act=%0d req=%0d", outstanding_o, exp_out);
        else passed++;
        total++;
        if (tio_mask_o !== mask) $display("FAIL mask_snapshot act=%h req=%h", tio_mask_o, mask);
        else passed++;
        err_i  = err;
        en_cnt = 0;
        for (int i = 0; i < nwait; i++) begin
            if (enable_o === 1'b1) en_cnt++;
            if (!exp_to && i == nwait - 1) complete_i = 1'b1;
            step();
        end
        complete_i = 1'b0;
        err_i      = 4'h0;
        total++;
        if (en_cnt != nwait || enable_o !== 1'b0)
            $display("FAIL enable_window act=%0d_hi_then_%0b req=%0d_hi_then_0", en_cnt, enable_o, nwait);
        else passed++;
        collect_done(stall);
    endtask

    task automatic test_reset();
        aclk_rst = 1'b1;
        repeat (3) step();
        total++;
        if (enable_o !== 1'b0 || m_done_tvalid !== 1'b0 || m_done_tdata !== 7'd0 ||
            tio_mask_o !== 4'h0 || outstanding_o !== 3'd0 || release_err_o !== 1'b0)
            $display("FAIL reset_outputs act=en%0b v%0b d%h m%h o%0d e%0b req=all_zero",
                     enable_o, m_done_tvalid, m_done_tdata, tio_mask_o, outstanding_o, release_err_o);
        else passed++;
        aclk_rst = 1'b0;
        step();
        total++;
        if (s_evt_tready !== 1'b1) $display("FAIL reset_ready act=%0b req=1", s_evt_tready);
        else passed++;
        exp_out = '0;
        exp_err = 1'b0;
    endtask

    task automatic test_complete();
        do_event(2'd2, 4'h0, 10, 4'h0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_event(2'd1, 4'h5, 0, 4'hA, 0, 1'b0);
        do_event(2'd0, 4'hF, 7, 4'h3, 0, 1'b0);
    endtask

    task automatic test_full();
        while (exp_out != 0) pulse_release();
        for (int i = 0; i < 4; i++) do_event(2'(i), 4'(i + 8), 3 + i, 4'(i), 0, 1'b0);
        s_evt_tvalid = 1'b1;
        s_evt_tdata  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (s_evt_tready !== 1'b0 || outstanding_o !== 3'd4)
                $display("FAIL full_block act=r%0b o%0d req=r0 o4", s_evt_tready, outstanding_o);
            else passed++;
            step();
        end
        pulse_release();
        total++;
        if (s_evt_tready !== 1'b1) $display("FAIL ready_after_release act=%0b req=1", s_evt_tready);
        else passed++;
        do_event(2'd1, 4'h6, 5, 4'h9, 0, 1'b0);
    endtask

    task automatic test_release_accounting();
        pulse_release();
        pulse_release();
        do_event(2'd3, 4'hC, 4, 4'h0, 0, 1'b1);
        pulse_release();
        pulse_release();
        pulse_release();
    endtask

    task automatic test_backpressure();
        do_event(2'd2, 4'h1, 6, 4'h5, 20, 1'b0);
    endtask

    task automatic test_reset_mid_event();
        s_evt_tvalid = 1'b1;
        s_evt_tdata  = 2'd3;
        tio_mask_i   = 4'h9;
        step();
        s_evt_tvalid = 1'b0;
        repeat (3) step();
        tio_mask_i = 4'h6;
        step();
        total++;
        if (tio_mask_o !== 4'h9 || enable_o !== 1'b1)
            $display("FAIL mask_hold act=m%h en%0b req=m9 en1", tio_mask_o, enable_o);
        else passed++;
        aclk_rst = 1'b1;
        step();
        aclk_rst = 1'b0;
        total++;
        if (enable_o !== 1'b0 || outstanding_o !== 3'd0 || s_evt_tready !== 1'b1 || release_err_o !== 1'b0)
            $display("FAIL reset_mid_wait act=en%0b o%0d r%0b e%0b req=en0 o0 r1 e0",
                     enable_o, outstanding_o, s_evt_tready, release_err_o);
        else passed++;
        exp_out = '0;
        exp_err = 1'b0;
        complete_i    = 1'b1;
        m_done_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (m_done_tvalid !== 1'b0) $display("FAIL stray_done cyc=%0d act=%0b req=0", i, m_done_tvalid);
            else passed++;
            step();
        end
        complete_i    = 1'b0;
        m_done_tready = 1'b0;
    endtask

    initial begin
        aclk_rst = 1'b1; s_evt_tvalid = 1'b0; s_evt_tdata = '0; tio_mask_i = '0;
        complete_i = 1'b0; err_i = '0; m_done_tready = 1'b0; release_i = 1'b0;
        test_reset();
        test_complete();
        test_timeout();
        test_full();
        test_release_accounting();
        test_backpressure();
        test_reset_mid_event();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain act=%0d req=0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
